// File: rtl/serial_add_seq_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// sum/cout with done/ack handshake out.
interface serial_add_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             ack;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, op_a, op_b, ack,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, op_a, op_b, ack,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial unsigned adder: one sum bit per clock, LSB first, through a
// single sum/carry stage with a registered carry; result held until ack.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_add_seq_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic             cout_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       stage_s;
   logic [WIDTH-1:0] sum_shift_s;

   // Single-bit sum/carry stage: returns {carry_out, sum_bit}.
   function automatic logic [1:0] sum_carry(input logic a, input logic b, input logic c);
      logic p;
      p = a ^ b;
      return {(a & b) | (c & p), p ^ c};
   endfunction

   // Next-state selection; start is only looked at in IDLE, ack only in DONE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) state_nxt_s = RUN;
            else           state_nxt_s = IDLE;
         end
         RUN: begin
            if (cnt_r == CNT_LAST) state_nxt_s = DONE;
            else                   state_nxt_s = RUN;
         end
         DONE: begin
            if (bus.ack) state_nxt_s = IDLE;
            else         state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Current bit through the adder stage and the sum with it inserted at the MSB.
   always_comb begin
      stage_s                  = sum_carry(a_r[0], b_r[0], carry_r);
      sum_shift_s              = sum_r >> 1'b1;
      sum_shift_s[WIDTH-1]     = stage_s[0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Status flags registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == RUN);
         done_r <= (state_nxt_s == DONE);
      end
   end

   // Operand capture, serial shifting, carry chain and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_r     <= bus.op_a;
                  b_r     <= bus.op_b;
                  sum_r   <= '0;
                  carry_r <= 1'b0;
                  cout_r  <= 1'b0;
                  cnt_r   <= '0;
               end else begin
                  a_r <= a_r;
               end
            end
            RUN: begin
               a_r     <= a_r >> 1'b1;
               b_r     <= b_r >> 1'b1;
               sum_r   <= sum_shift_s;
               carry_r <= stage_s[1];
               cnt_r   <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) cout_r <= stage_s[1];
               else                   cout_r <= cout_r;
            end
            DONE: begin
               sum_r <= sum_r;
            end
            default: begin
               sum_r <= sum_r;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and randomised bench for serial_add_seq at WIDTH 1, 8 and 32,
// checked every cycle against a transaction-level a+b model.
module tb_serial_add_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  start_v;
   logic [2:0]  ack_v;
   logic [31:0] op_a_v;
   logic [31:0] op_b_v;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   serial_add_seq_if #(.WIDTH(1))  bus1 ();
   serial_add_seq_if #(.WIDTH(8))  bus8 ();
   serial_add_seq_if #(.WIDTH(32)) bus32 ();

   assign bus1.start  = start_v[0];
   assign bus1.ack    = ack_v[0];
   assign bus1.op_a   = op_a_v[0:0];
   assign bus1.op_b   = op_b_v[0:0];
   assign bus8.start  = start_v[1];
   assign bus8.ack    = ack_v[1];
   assign bus8.op_a   = op_a_v[7:0];
   assign bus8.op_b   = op_b_v[7:0];
   assign bus32.start = start_v[2];
   assign bus32.ack   = ack_v[2];
   assign bus32.op_a  = op_a_v;
   assign bus32.op_b  = op_b_v;

   serial_add_seq #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   serial_add_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_add_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   logic [2:0]  d_busy;
   logic [2:0]  d_done;
   logic [2:0]  d_cout;
   logic [31:0] d_sum [3];

   assign d_busy   = {bus32.busy, bus8.busy, bus1.busy};
   assign d_done   = {bus32.done, bus8.done, bus1.done};
   assign d_cout   = {bus32.cout, bus8.cout, bus1.cout};
   assign d_sum[0] = {31'd0, bus1.sum};
   assign d_sum[1] = {24'd0, bus8.sum};
   assign d_sum[2] = bus32.sum;

   function automatic int lane_w(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 8 : 32);
   endfunction

   // Returns {cout, sum} of the unsigned w-bit addition.
   function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mask;
      logic [32:0] f;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      f = {1'b0, a & mask} + {1'b0, b & mask};
      f[32] = f[w];
      f[31:0] = f[31:0] & mask;
      return f;
   endfunction

   // Transaction-level model: accepts a job in idle, stays busy for w cycles,
   // then presents a+b until acknowledged.
   logic        m_busy [3];
   logic        m_done [3];
   logic        m_cout [3];
   logic [31:0] m_sum  [3];
   logic [31:0] m_a    [3];
   logic [31:0] m_b    [3];
   int          m_left [3];
   logic [32:0] m_res  [3];

   always_comb begin
      for (int i = 0; i < 3; i++) m_res[i] = ref_add(lane_w(i), m_a[i], m_b[i]);
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_cout[i] <= 1'b0;
            m_sum[i]  <= 32'd0;
            m_a[i]    <= 32'd0;
            m_b[i]    <= 32'd0;
            m_left[i] <= 0;
         end else if (m_busy[i]) begin
            if (m_left[i] == 1) begin
               m_busy[i] <= 1'b0;
               m_done[i] <= 1'b1;
               m_sum[i]  <= m_res[i][31:0];
               m_cout[i] <= m_res[i][32];
            end
            m_left[i] <= m_left[i] - 1;
         end else if (m_done[i]) begin
            if (ack_v[i]) m_done[i] <= 1'b0;
         end else if (start_v[i]) begin
            m_busy[i] <= 1'b1;
            m_left[i] <= lane_w(i);
            m_a[i]    <= op_a_v;
            m_b[i]    <= op_b_v;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One operation on a lane: start, wait for done (bounded), optional hold,
   // then ack (optionally with start on the same edge).
   task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_sum, input logic exp_cout,
                         input int hold, input bit disturb, input bit ack_start);
      int w;
      int cyc;
      int busy_cnt;
      w = lane_w(lane);
      start_v[lane] = 1'b1;
      op_a_v = a;
      op_b_v = b;
      cyc = 0;
      busy_cnt = 0;
      while (cyc < w + 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start_v[lane] = 1'b0;
            op_a_v = ~a;
            op_b_v = ~b;
         end
         if (disturb && cyc == 3) begin
            start_v[lane] = 1'b1;
            op_a_v = 32'h0000_0011;
            op_b_v = 32'h0000_0077;
         end
         if (disturb && cyc == 4) start_v[lane] = 1'b0;
         if (d_busy[lane]) busy_cnt++;
         if (d_done[lane]) break;
      end
      chk($sformatf("lane%0d done seen", lane), 32'(d_done[lane]), 32'd1);
      // done is first visible at the (w+1)th falling edge after start was raised
      chk($sformatf("lane%0d latency", lane), 32'(cyc), 32'(w + 1));
      chk($sformatf("lane%0d busy cycles", lane), 32'(busy_cnt), 32'(w));
      chk($sformatf("lane%0d sum", lane), d_sum[lane], exp_sum);
      chk($sformatf("lane%0d cout", lane), 32'(d_cout[lane]), 32'(exp_cout));
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk($sformatf("lane%0d held done", lane), 32'(d_done[lane]), 32'd1);
         chk($sformatf("lane%0d held sum", lane), d_sum[lane], exp_sum);
         chk($sformatf("lane%0d held cout", lane), 32'(d_cout[lane]), 32'(exp_cout));
      end
      ack_v[lane] = 1'b1;
      if (ack_start) start_v[lane] = 1'b1;
      @(negedge clk);
      ack_v[lane] = 1'b0;
      start_v[lane] = 1'b0;
      chk($sformatf("lane%0d done after ack", lane), 32'(d_done[lane]), 32'd0);
      chk($sformatf("lane%0d busy after ack", lane), 32'(d_busy[lane]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [32:0] r;
      logic [31:0] ra;
      logic [31:0] rb;
      rst_n   = 1'b0;
      start_v = 3'b000;
      ack_v   = 3'b000;
      op_a_v  = 32'd0;
      op_b_v  = 32'd0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lane%0d reset busy", i), 32'(d_busy[i]), 32'd0);
         chk($sformatf("lane%0d reset done", i), 32'(d_done[i]), 32'd0);
         chk($sformatf("lane%0d reset sum", i), d_sum[i], 32'd0);
         chk($sformatf("lane%0d reset cout", i), 32'(d_cout[i]), 32'd0);
      end
      rst_n = 1'b1;

      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("lane%0d model busy", i), 32'(d_busy[i]), 32'(m_busy[i]));
               chk($sformatf("lane%0d model done", i), 32'(d_done[i]), 32'(m_done[i]));
               if (!m_busy[i]) begin
                  chk($sformatf("lane%0d model sum", i), d_sum[i], m_sum[i]);
                  chk($sformatf("lane%0d model cout", i), 32'(d_cout[i]), 32'(m_cout[i]));
               end
            end
         end
      join_none

      @(negedge clk);
      run_op(1, 32'h3C, 32'h5A, 32'h96, 1'b0, 0, 1'b0, 1'b0);
      run_op(1, 32'hFF, 32'h01, 32'h00, 1'b1, 0, 1'b0, 1'b0);
      run_op(1, 32'hFF, 32'hFF, 32'hFE, 1'b1, 0, 1'b0, 1'b0);
      run_op(1, 32'h00, 32'h00, 32'h00, 1'b0, 0, 1'b0, 1'b0);
      run_op(1, 32'h0F, 32'h01, 32'h10, 1'b0, 0, 1'b1, 1'b0);
      run_op(1, 32'h12, 32'h34, 32'h46, 1'b0, 20, 1'b0, 1'b1);
      run_op(1, 32'h7F, 32'h01, 32'h80, 1'b0, 0, 1'b0, 1'b0);

      // Reset in the middle of a RUN, sampled between clock edges.
      start_v[1] = 1'b1;
      op_a_v = 32'h3C;
      op_b_v = 32'h5A;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (4) @(negedge clk);
      chk("lane1 busy before reset", 32'(d_busy[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("lane1 async reset busy", 32'(d_busy[1]), 32'd0);
      chk("lane1 async reset done", 32'(d_done[1]), 32'd0);
      chk("lane1 async reset sum", d_sum[1], 32'd0);
      chk("lane1 async reset cout", 32'(d_cout[1]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 32'h80, 32'h80, 32'h00, 1'b1, 0, 1'b0, 1'b0);

      run_op(0, 32'h1, 32'h1, 32'h0, 1'b1, 0, 1'b0, 1'b0);
      run_op(0, 32'h1, 32'h0, 32'h1, 1'b0, 0, 1'b0, 1'b0);
      run_op(0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
      run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0);
      run_op(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);

      for (int lane = 0; lane < 3; lane++) begin
         for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom;
            r = ref_add(lane_w(lane), ra, rb);
            run_op(lane, ra, rb, r[31:0], r[32], 0, 1'b0, 1'b0);
         end
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
